// File: rtl/drum_acc_pkg.sv
// Shared types and constants for the drum_acc product accumulator.
package drum_acc_pkg;
   localparam int CNT_W = 8;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_e;
endpackage

// File: rtl/drum_acc_if.sv
// Product-beat input stream and frame-result output stream of drum_acc.
interface drum_acc_if #(
   parameter int PW = 8,
   parameter int AW = 16
) ();
   import drum_acc_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic [PW-1:0]           in_prod;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [AW-1:0]    out_sum;
   logic [CNT_W-1:0]        out_cnt;
   logic                    out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_cnt, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_cnt, out_ovf
   );
endinterface

// File: rtl/drum_oc2tc.sv
// Converts a sign-inverted (ones'-complement) product to AW-bit two's complement.
module drum_oc2tc #(
   parameter int PW = 8,
   parameter int AW = 16
) (
   input  logic [PW-1:0]        prod_i,
   output logic signed [AW-1:0] val_o
);
   logic signed [PW-1:0] prod_s;

   assign prod_s = prod_i;

   // Negative codes sit one below their value; all-ones lands on zero.
   always_comb begin
      if (prod_i[PW-1]) val_o = AW'(prod_s) + AW'(1);
      else              val_o = AW'(prod_i);
   end
endmodule

// File: rtl/drum_acc.sv
// Frame accumulator for signed products; DRUM_ACC_SAT_EN selects saturating
// accumulation, otherwise the accumulator wraps and only flags overflow.
module drum_acc
   import drum_acc_pkg::*;
#(
   parameter int PW  = 8,
   parameter int AW  = 16,
   parameter int LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   drum_acc_if.slave  bus
);
   state_e                  state_q, state_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic signed [AW-1:0]    val;
   logic signed [AW:0]      sum_w;
   logic                    sum_ovf;
   logic                    in_ready_w;
   logic                    accept;
   logic                    close;

`ifdef DRUM_ACC_SAT_EN
   function automatic logic signed [AW-1:0] acc_next(input logic signed [AW:0] s);
      if (s[AW] != s[AW-1]) return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      return s[AW-1:0];
   endfunction
`else
   function automatic logic signed [AW-1:0] acc_next(input logic signed [AW:0] s);
      return s[AW-1:0];
   endfunction
`endif

   drum_oc2tc #(.PW(PW), .AW(AW)) u_conv (
      .prod_i (bus.in_prod),
      .val_o  (val)
   );

   // One guard bit exposes signed overflow as a mismatch of the top two bits.
   assign sum_w   = {acc_q[AW-1], acc_q} + {val[AW-1], val};
   assign sum_ovf = sum_w[AW] ^ sum_w[AW-1];

   assign in_ready_w = (state_q == ACC) && !rst;
   assign accept     = bus.in_valid && in_ready_w;
   assign close      = accept && ((cnt_q == CNT_W'(LEN - 1)) || bus.in_last);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (state_q == ACC) begin
         if (accept) begin
            acc_d = acc_next(sum_w);
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | sum_ovf;
         end
         if (close) state_d = HOLD;
      end else if (bus.out_ready) begin
         state_d = ACC;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == HOLD) && !rst;
   assign bus.out_sum   = acc_q;
   assign bus.out_cnt   = cnt_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_drum_acc.sv
// Directed bench for drum_acc: a 16-bit and a 10-bit accumulator share clock and reset.
module tb_drum_acc;
   logic clk;
   logic rst;
   int   checks;
   int   passed;

   drum_acc_if #(.PW(8), .AW(16)) a ();
   drum_acc_if #(.PW(8), .AW(10)) b ();

   drum_acc #(.PW(8), .AW(16), .LEN(8)) dut (.clk(clk), .rst(rst), .bus(a));
   drum_acc #(.PW(8), .AW(10), .LEN(8)) dut10 (.clk(clk), .rst(rst), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input logic [7:0] p, input logic last);
      a.in_valid = 1'b1;
      a.in_prod  = p;
      a.in_last  = last;
      tick();
   endtask

   task automatic beat_b(input logic [7:0] p, input logic last);
      b.in_valid = 1'b1;
      b.in_prod  = p;
      b.in_last  = last;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (a.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", a.out_valid); else passed++;
      checks++; if (a.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", a.in_ready); else passed++;
      checks++; if (a.out_sum !== 16'h0000) $display("FAIL rst_out_sum: got %h expected 0000", a.out_sum); else passed++;
      checks++; if (a.out_cnt !== 8'd0) $display("FAIL rst_out_cnt: got %0d expected 0", a.out_cnt); else passed++;
      checks++; if (a.out_ovf !== 1'b0) $display("FAIL rst_out_ovf: got %b expected 0", a.out_ovf); else passed++;
      rst = 1'b0;
      #1;
      checks++; if (a.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", a.in_ready); else passed++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            checks++; if (a.out_valid !== 1'b0) $display("FAIL b2b_early_valid: got %b expected 0", a.out_valid); else passed++;
         end
         beat_a(8'h06, 1'b0);
      end
      a.in_valid = 1'b0;
      checks++; if (a.out_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", a.out_valid); else passed++;
      checks++; if (a.out_sum !== 16'h0030) $display("FAIL b2b_sum: got %h expected 0030", a.out_sum); else passed++;
      checks++; if (a.out_cnt !== 8'd8) $display("FAIL b2b_cnt: got %0d expected 8", a.out_cnt); else passed++;
      checks++; if (a.out_ovf !== 1'b0) $display("FAIL b2b_ovf: got %b expected 0", a.out_ovf); else passed++;
      checks++; if (a.in_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %b expected 0", a.in_ready); else passed++;
      a.out_ready = 1'b1;
      tick();
      a.out_ready = 1'b0;
      checks++; if (a.out_valid !== 1'b0) $display("FAIL b2b_release: got %b expected 0", a.out_valid); else passed++;
   endtask

   task automatic test_early_last();
      beat_a(8'h06, 1'b0);
      beat_a(8'hF9, 1'b0);
      beat_a(8'hFF, 1'b0);
      beat_a(8'h00, 1'b1);
      a.in_valid = 1'b0;
      a.in_last  = 1'b0;
      checks++; if (a.out_valid !== 1'b1) $display("FAIL last_valid: got %b expected 1", a.out_valid); else passed++;
      checks++; if (a.out_sum !== 16'h0000) $display("FAIL last_sum: got %h expected 0000", a.out_sum); else passed++;
      checks++; if (a.out_cnt !== 8'd4) $display("FAIL last_cnt: got %0d expected 4", a.out_cnt); else passed++;
      a.out_ready = 1'b1;
      tick();
      a.out_ready = 1'b0;
   endtask

   task automatic test_hold();
      beat_a(8'h02, 1'b0);
      beat_a(8'h02, 1'b0);
      beat_a(8'h02, 1'b1);
      a.in_valid = 1'b1;
      a.in_prod  = 8'h05;
      a.in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (a.out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b expected 1", i, a.out_valid); else passed++;
         checks++; if (a.in_ready !== 1'b0) $display("FAIL hold_ready[%0d]: got %b expected 0", i, a.in_ready); else passed++;
         checks++; if (a.out_sum !== 16'h0006) $display("FAIL hold_sum[%0d]: got %h expected 0006", i, a.out_sum); else passed++;
         checks++; if (a.out_cnt !== 8'd3) $display("FAIL hold_cnt[%0d]: got %0d expected 3", i, a.out_cnt); else passed++;
         tick();
      end
      a.out_ready = 1'b1;
      tick();
      a.out_ready = 1'b0;
      checks++; if (a.in_ready !== 1'b1) $display("FAIL bubble_ready: got %b expected 1", a.in_ready); else passed++;
      checks++; if (a.out_cnt !== 8'd0) $display("FAIL bubble_cnt: got %0d expected 0", a.out_cnt); else passed++;
      tick();
      checks++; if (a.out_cnt !== 8'd1) $display("FAIL after_bubble_cnt: got %0d expected 1", a.out_cnt); else passed++;
      checks++; if (a.out_sum !== 16'h0005) $display("FAIL after_bubble_sum: got %h expected 0005", a.out_sum); else passed++;
      beat_a(8'h00, 1'b1);
      a.in_valid = 1'b0;
      a.in_last  = 1'b0;
      checks++; if (a.out_cnt !== 8'd2) $display("FAIL after_bubble_frame_cnt: got %0d expected 2", a.out_cnt); else passed++;
      a.out_ready = 1'b1;
      tick();
      a.out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [9:0] exp_pos;
      logic [9:0] exp_neg;
`ifdef DRUM_ACC_SAT_EN
      exp_pos = 10'h1FF;
      exp_neg = 10'h200;
`else
      exp_pos = 10'h3F8;
      exp_neg = 10'h008;
`endif
      for (int i = 0; i < 8; i++) beat_b(8'h7F, 1'b0);
      b.in_valid = 1'b0;
      checks++; if (b.out_valid !== 1'b1) $display("FAIL ovf_pos_valid: got %b expected 1", b.out_valid); else passed++;
      checks++; if (b.out_sum !== exp_pos) $display("FAIL ovf_pos_sum: got %h expected %h", b.out_sum, exp_pos); else passed++;
      checks++; if (b.out_ovf !== 1'b1) $display("FAIL ovf_pos_flag: got %b expected 1", b.out_ovf); else passed++;
      b.out_ready = 1'b1;
      tick();
      b.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) beat_b(8'h80, 1'b0);
      b.in_valid = 1'b0;
      checks++; if (b.out_sum !== exp_neg) $display("FAIL ovf_neg_sum: got %h expected %h", b.out_sum, exp_neg); else passed++;
      checks++; if (b.out_ovf !== 1'b1) $display("FAIL ovf_neg_flag: got %b expected 1", b.out_ovf); else passed++;
      b.out_ready = 1'b1;
      tick();
      b.out_ready = 1'b0;
      checks++; if (b.out_ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", b.out_ovf); else passed++;
   endtask

   task automatic test_reset_abort();
      a.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) beat_a(8'h01, 1'b0);
      a.in_valid = 1'b0;
      checks++; if (a.out_cnt !== 8'd3) $display("FAIL abort_partial_cnt: got %0d expected 3", a.out_cnt); else passed++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (a.out_cnt !== 8'd0) $display("FAIL abort_cnt: got %0d expected 0", a.out_cnt); else passed++;
      checks++; if (a.out_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", a.out_valid); else passed++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (a.out_valid !== 1'b0) $display("FAIL abort_early_valid[%0d]: got %b expected 0", i, a.out_valid); else passed++;
         beat_a(8'h01, 1'b0);
      end
      a.in_valid = 1'b0;
      checks++; if (a.out_valid !== 1'b1) $display("FAIL abort_valid_final: got %b expected 1", a.out_valid); else passed++;
      checks++; if (a.out_sum !== 16'h0008) $display("FAIL abort_sum: got %h expected 0008", a.out_sum); else passed++;
      checks++; if (a.out_cnt !== 8'd8) $display("FAIL abort_cnt_final: got %0d expected 8", a.out_cnt); else passed++;
      tick();
      a.out_ready = 1'b0;
      checks++; if (a.out_valid !== 1'b0) $display("FAIL abort_release: got %b expected 0", a.out_valid); else passed++;
   endtask

   initial begin
      checks      = 0;
      passed      = 0;
      rst         = 1'b1;
      a.in_valid  = 1'b0;
      a.in_prod   = 8'h00;
      a.in_last   = 1'b0;
      a.out_ready = 1'b0;
      b.in_valid  = 1'b0;
      b.in_prod   = 8'h00;
      b.in_last   = 1'b0;
      b.out_ready = 1'b0;
      test_reset();
      test_back_to_back();
      test_early_last();
      test_hold();
      test_overflow();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
